instr_decode_stage: RTL



---
 rtl/instr_decode_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// Instruction-field decode stage with a two-entry skid buffer between fetch and execute.
// The stage emits registered decoded fields, a fully extended immediate and a count of output handshakes.
module instr_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [1:0]       out_type,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    logic [5:0]  opcode;
    logic [1:0]  itype;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  // EMPTY: nothing held; ONE: output register full; TWO: output and skid full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic fields_t decode(input logic [31:0] w);
    fields_t     f;
    logic [13:0] imm;
    imm      = w[13:0];
    f.opcode = w[31:26];
    f.itype  = w[25:24];
    f.rs1    = w[23:19];
    f.rd     = w[18:14];
    case (w[25:24])
      2'b00:   f.imm = {27'b0, imm[8:4]};
      2'b01:   f.imm = w[26] ? {18'b0, imm} : {{18{imm[13]}}, imm};
      2'b10:   f.imm = {{8{w[23]}}, w[23:0]};
      default: f.imm = {{18{imm[13]}}, imm};
    endcase
    return f;
  endfunction

  state_t          state_q, state_d;
  fields_t         out_q, out_d;
  fields_t         skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fields_t         dec_w;
  logic            accept, drain;

  assign dec_w  = decode(in_instr);
  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_d = ST_TWO;
          else if (!accept && drain) state_d = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath follows the same transitions; a flush leaves stale contents behind invalid flags.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, drain};
    if (!flush) begin
      case (state_q)
        ST_EMPTY: if (accept) out_d = dec_w;
        ST_ONE: begin
          if (accept && drain) out_d  = dec_w;
          else if (accept)     skid_d = dec_w;
        end
        ST_TWO:   if (drain) out_d = skid_q;
        default:  out_d = out_q;
      endcase
    end
  end

  always_comb begin
    out_valid  = (state_q != ST_EMPTY);
    in_ready   = (state_q != ST_TWO);
    out_opcode = out_q.opcode;
    out_type   = out_q.itype;
    out_rs1    = out_q.rs1;
    out_rd     = out_q.rd;
    out_imm    = out_q.imm;
    dec_count  = cnt_q;
  end

endmodule
